lcd_bus_arbiter: RTL and testbench

//  Shares the single lcd_write SPI datapath (9-bit word: bit8 = DC, bits7:0 = byte) between NREQ requesters.

---
 rtl/lcd_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_bus_arbiter
// Function : Burst-level arbiter sharing one lcd_write 9-bit SPI datapath.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bus_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 50000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_done,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   en_write_in,
    input  logic [9*NREQ-1:0] data_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   wr_done_out,
    output logic [8:0]        data,
    output logic              en_write,
    input  logic              wr_done,
    output logic              busy,
    output logic              timeout_err
);
    localparam int PTR_W = $clog2(NREQ);
    localparam int PW1   = PTR_W + 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PTR_W-1:0] c_last    = PTR_W'(NREQ - 1);
    localparam logic [WD_W-1:0]  c_wd_last = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic             c_wd_on   = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PTR_W-1:0] r_gidx;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] w_pick;
    logic [PTR_W-1:0] w_start_idx;
    logic             w_found;
    logic             w_start;
    logic             w_release;
    logic             w_accept;
    logic             w_timeout;
    logic             r_in_flight;
    logic [WD_W-1:0]  r_wd;

    // Round-robin search over clients 1..NREQ-1 starting at r_rr_ptr; client 0 never competes here.
    always_comb begin
        logic [PW1-1:0] cand;
        w_found = 1'b0;
        w_pick  = c_last;
        cand    = '0;
        for (int k = 0; k < NREQ - 1; k++) begin
            cand = {1'b0, r_rr_ptr} + PW1'(k);
            if (cand > {1'b0, c_last}) begin
                cand = cand - {1'b0, c_last};
            end
            if (!w_found && req[cand[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = cand[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_start_idx = '0;
        w_release   = 1'b0;
        w_accept    = 1'b0;
        w_timeout   = c_wd_on && (r_state != IDLE) && !en_write && !wr_done
                      && (r_wd == c_wd_last);
        case (r_state)
            IDLE: begin
                if (!init_done) begin
                    if (req[0]) begin
                        w_next  = GRANT;
                        w_start = 1'b1;
                    end
                end else if (w_found) begin
                    w_next      = GRANT;
                    w_start     = 1'b1;
                    w_start_idx = w_pick;
                end
            end
            GRANT: begin
                if (w_timeout) begin
                    w_next    = IDLE;
                    w_release = 1'b1;
                end else if (req[r_gidx]) begin
                    w_accept = en_write_in[r_gidx] && !r_in_flight;
                end else if (r_in_flight && !wr_done) begin
                    w_next = DRAIN;
                end else begin
                    w_next    = IDLE;
                    w_release = 1'b1;
                end
            end
            DRAIN: begin
                if (w_timeout || wr_done) begin
                    w_next    = IDLE;
                    w_release = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_gidx      <= '0;
            r_rr_ptr    <= PTR_W'(1);
            r_in_flight <= 1'b0;
            r_wd        <= '0;
            en_write    <= 1'b0;
            data        <= 9'h000;
            timeout_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_gidx <= w_start_idx;
            end
            if (w_release) begin
                r_rr_ptr <= (r_gidx == c_last) ? PTR_W'(1) : r_gidx + 1'b1;
            end
            en_write <= w_accept;
            if (w_accept) begin
                data <= data_in[9*r_gidx +: 9];
            end
            timeout_err <= w_timeout;
            // Setting on accept keeps a second strobe from slipping out before wr_done.
            if (w_timeout) begin
                r_in_flight <= 1'b0;
            end else if (w_accept) begin
                r_in_flight <= 1'b1;
            end else if (wr_done) begin
                r_in_flight <= 1'b0;
            end
            if (r_state == IDLE || en_write || wr_done || w_timeout || !c_wd_on) begin
                r_wd <= '0;
            end else begin
                r_wd <= r_wd + 1'b1;
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign gnt         = busy ? (NREQ'(1) << r_gidx) : '0;
    assign wr_done_out = gnt & {NREQ{wr_done}};

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bus_arbiter
// Function : Directed bench for lcd_bus_arbiter (long and short watchdog builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_arbiter;
    logic        clk;
    logic        rst_n;
    logic        init_done;
    logic [2:0]  req;
    logic [2:0]  ewi;
    logic [26:0] din;
    logic        wr_done;

    logic [2:0]  gnt, wdo, gnt_b, wdo_b;
    logic [8:0]  data, data_b;
    logic        en_write, busy, to_err, en_write_b, busy_b, to_b;

    int checks = 0;
    int errors = 0;

    lcd_bus_arbiter #(.NREQ(3), .TIMEOUT(50000)) u_dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .init_done(init_done), .req(req),
        .en_write_in(ewi), .data_in(din), .gnt(gnt), .wr_done_out(wdo),
        .data(data), .en_write(en_write), .wr_done(wr_done), .busy(busy),
        .timeout_err(to_err)
    );

    lcd_bus_arbiter #(.NREQ(3), .TIMEOUT(16)) u_dut_wd (
        .sys_clk(clk), .sys_rst_n(rst_n), .init_done(init_done), .req(req),
        .en_write_in(ewi), .data_in(din), .gnt(gnt_b), .wr_done_out(wdo_b),
        .data(data_b), .en_write(en_write_b), .wr_done(wr_done), .busy(busy_b),
        .timeout_err(to_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL sim_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input int i, input logic [8:0] w);
        ewi              = '0;
        ewi[i]           = 1'b1;
        din[9*i +: 9]    = w;
        step();
        ewi = '0;
        chk("en_write", en_write, 1);
        chk("data", data, w);
        wr_done = 1'b1;
        #1;
        chk("wr_done_out", wdo, 3'b001 << i);
        step();
        wr_done = 1'b0;
        chk("en_write_low", en_write, 0);
    endtask

    task automatic burst(input int i, input int other, input logic [8:0] base);
        for (int k = 0; k < 3; k++) begin
            write_word(i, base + 9'(k));
        end
        req[i] = 1'b0;
        step();
        chk("gap_gnt", gnt, 0);
        req[i] = 1'b1;
        step();
        chk("next_gnt", gnt, 3'b001 << other);
    endtask

    logic [8:0] words [10] = '{9'h011, 9'h13A, 9'h0AB, 9'h1FF, 9'h000,
                               9'h155, 9'h0AA, 9'h12C, 9'h03C, 9'h1E1};

    initial begin
        rst_n = 1'b0; init_done = 1'b0; req = '0; ewi = '0; din = '0; wr_done = 1'b0;
        step(); step();
        chk("rst_gnt", gnt, 0);
        chk("rst_wdo", wdo, 0);
        chk("rst_data", data, 0);
        chk("rst_en_write", en_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", to_err, 0);
        rst_n = 1'b1;
        step();

        // Init phase: only client 0 is eligible.
        req = 3'b111;
        step();
        chk("init_gnt", gnt, 3'b001);
        chk("init_busy", busy, 1);
        for (int k = 0; k < 10; k++) begin
            write_word(0, words[k]);
        end
        req = 3'b000;
        step();
        chk("init_release_gnt", gnt, 0);
        chk("init_release_busy", busy, 0);

        // Round robin between clients 1 and 2 with an idle gap between grants.
        init_done = 1'b1;
        req = 3'b110;
        step();
        chk("rr_first_gnt", gnt, 3'b010);
        burst(1, 2, 9'h020);
        burst(2, 1, 9'h140);

        // Drain: req drops with a word in flight, wr_done arrives 20 cycles after en_write.
        ewi = 3'b010; din[17:9] = 9'h1C3;
        step();
        chk("drain_en_write", en_write, 1);
        ewi = '0; req[1] = 1'b0;
        step();
        chk("drain_gnt", gnt, 3'b010);
        chk("drain_busy", busy, 1);
        repeat (18) step();
        chk("drain_hold_gnt", gnt, 3'b010);
        chk("drain_hold_wdo", wdo, 0);
        step();
        wr_done = 1'b1;
        #1;
        chk("drain_wdo", wdo, 3'b010);
        chk("drain_gnt_at_done", gnt, 3'b010);
        req = 3'b010;
        step();
        wr_done = 1'b0;
        chk("drain_release_gnt", gnt, 0);
        chk("drain_release_busy", busy, 0);
        step();
        chk("regrant_gnt", gnt, 3'b010);

        // Dropped strobes: non-granted client and a second write before wr_done.
        ewi = 3'b110; din[17:9] = 9'h0F0; din[26:18] = 9'h1AA;
        step();
        chk("drop_first_en", en_write, 1);
        chk("drop_first_data", data, 9'h0F0);
        ewi = 3'b010; din[17:9] = 9'h055;
        step();
        chk("drop_second_en", en_write, 0);
        chk("drop_second_data", data, 9'h0F0);
        ewi = '0;
        step();
        chk("drop_quiet_en", en_write, 0);
        wr_done = 1'b1;
        #1;
        chk("drop_wdo", wdo, 3'b010);
        step();
        wr_done = 1'b0;
        ewi = 3'b100;
        step();
        chk("drop_other_en", en_write, 0);
        ewi = '0;

        // Asynchronous reset while draining.
        ewi = 3'b010; din[17:9] = 9'h077;
        step();
        chk("pre_rst_en", en_write, 1);
        ewi = '0; req = '0;
        step();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_gnt", gnt, 3'b010);
        rst_n = 1'b0; wr_done = 1'b1; init_done = 1'b1; req = 3'b100;
        #1;
        chk("arst_gnt", gnt, 0);
        chk("arst_wdo", wdo, 0);
        chk("arst_data", data, 0);
        chk("arst_en_write", en_write, 0);
        chk("arst_busy", busy, 0);
        chk("arst_timeout", to_err, 0);
        step(); step();
        wr_done = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_rst_gnt", gnt, 3'b100);
        chk("post_rst_busy", busy, 1);
        chk("post_rst_gnt_wd", gnt_b, 3'b100);

        // Watchdog (TIMEOUT=16) revokes an idle grant; client 1 is pending.
        req = 3'b110;
        repeat (15) step();
        chk("wd_hold_gnt", gnt_b, 3'b100);
        chk("wd_hold_err", to_b, 0);
        step();
        chk("wd_err", to_b, 1);
        chk("wd_gnt_clear", gnt_b, 0);
        chk("wd_busy_clear", busy_b, 0);
        chk("wd_long_unaffected", gnt, 3'b100);
        step();
        chk("wd_next_gnt", gnt_b, 3'b010);
        chk("wd_err_pulse_end", to_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
